// File: rtl/chip7458_tester.sv
// Exhaustive tester for a 7458-style dual AND-OR gate: walks all 1024 input
// vectors, compares the device response to the ideal function, logs errors.
module chip7458_tester #(
    parameter int SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    output logic        p1a,
    output logic        p1b,
    output logic        p1c,
    output logic        p1d,
    output logic        p1e,
    output logic        p1f,
    output logic        p2a,
    output logic        p2b,
    output logic        p2c,
    output logic        p2d,
    input  logic        p1y_in,
    input  logic        p2y_in,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [10:0] err_cnt,
    output logic        first_err_valid,
    output logic [9:0]  first_err_vec
);

    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CHECK, ST_DONE} state_t;

    state_t      state_q, state_d;
    logic [9:0]  vec_q, vec_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [10:0] err_q, err_d;
    logic        fv_q, fv_d;
    logic [9:0]  fvec_q, fvec_d;

    logic        exp1, exp2, mismatch;
    logic [9:0]  stim;

    assign exp1     = (vec_q[0] & vec_q[1] & vec_q[2]) | (vec_q[3] & vec_q[4] & vec_q[5]);
    assign exp2     = (vec_q[6] & vec_q[7]) | (vec_q[8] & vec_q[9]);
    assign mismatch = (p1y_in != exp1) || (p2y_in != exp2);

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        fv_d    = fv_q;
        fvec_d  = fvec_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                // abort wins over start; a DONE result is discarded on abort
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (start) begin
                    state_d = ST_SETTLE;
                    vec_d   = '0;
                    cnt_d   = '0;
                    err_d   = '0;
                    fv_d    = 1'b0;
                    fvec_d  = '0;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'(SETTLE - 1)) state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    // at most 1024 mismatches, so 11 bits never wrap
                    if (mismatch) begin
                        err_d = err_q + 11'd1;
                        if (!fv_q) begin
                            fv_d   = 1'b1;
                            fvec_d = vec_q;
                        end
                    end
                    if (vec_q == 10'd1023) begin
                        state_d = ST_DONE;
                    end else begin
                        vec_d   = vec_q + 10'd1;
                        cnt_d   = '0;
                        state_d = ST_SETTLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            fv_q    <= 1'b0;
            fvec_q  <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            fv_q    <= fv_d;
            fvec_q  <= fvec_d;
        end
    end

    assign busy            = (state_q == ST_SETTLE) || (state_q == ST_CHECK);
    assign done            = (state_q == ST_DONE);
    assign pass            = done && (err_q == 11'd0);
    assign err_cnt         = err_q;
    assign first_err_valid = fv_q;
    assign first_err_vec   = fvec_q;

    // pins follow vec only while a run is active
    assign stim = busy ? vec_q : 10'd0;
    assign {p2d, p2c, p2b, p2a, p1f, p1e, p1d, p1c, p1b, p1a} = stim;

endmodule
